// File: rtl/phys_free_list.sv
// Physical-register free list: circular FIFO of free indices plus a free bit-vector.
// Latency: grants and granted indices are combinational; state updates at the next edge.
// Backpressure: all-or-nothing grant; alloc_stall when requests exceed the free count.
module phys_free_list #(
  parameter int NUM_PREGS = 64,
  parameter int NUM_ARCH  = 32,
  parameter int DEPTH     = NUM_PREGS - NUM_ARCH
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             alloc_req_1,
  input  logic                             alloc_req_2,
  output logic                             alloc_gnt_1,
  output logic                             alloc_gnt_2,
  output logic [$clog2(NUM_PREGS)-1:0]     alloc_preg_1,
  output logic [$clog2(NUM_PREGS)-1:0]     alloc_preg_2,
  output logic                             alloc_stall,
  input  logic                             rt_flag_1,
  input  logic [$clog2(NUM_PREGS)-1:0]     fp_i_1,
  input  logic                             rt_flag_2,
  input  logic [$clog2(NUM_PREGS)-1:0]     fp_i_2,
  output logic [$clog2(DEPTH+1)-1:0]       free_count,
  output logic                             empty,
  output logic                             ovf_err,
  output logic                             dbl_err
);

  localparam int IDXW = $clog2(NUM_PREGS);
  localparam int PTRW = $clog2(DEPTH);
  localparam int CNTW = $clog2(DEPTH + 1);
  localparam logic [CNTW:0]        DEPTH_W   = (CNTW + 1)'(DEPTH);
  localparam logic [NUM_PREGS-1:0] FREE_INIT = {{DEPTH{1'b1}}, {NUM_ARCH{1'b0}}};

  logic [IDXW-1:0]      entry_q [DEPTH];
  logic [IDXW-1:0]      entry_d [DEPTH];
  logic [PTRW-1:0]      head_q, head_d, tail_q, tail_d, head_p1, tail_p1;
  logic [CNTW-1:0]      count_q, count_d;
  logic [NUM_PREGS-1:0] free_vec_q, free_vec_d;
  logic                 ovf_q, ovf_d, dbl_q, dbl_d;

  logic [1:0]    need, n_gnt;
  logic          fits;
  logic [CNTW:0] base, cnt_sum;
  logic          dbl1, acc1, ovf1, dbl2, acc2, ovf2;

  // Circular pointer increment; DEPTH need not be a power of two.
  function automatic logic [PTRW-1:0] ptr_inc(input logic [PTRW-1:0] p);
    return (p == PTRW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  // Allocation: all-or-nothing grant, slot 1 takes the head entry first.
  always_comb begin
    need         = {1'b0, alloc_req_1} + {1'b0, alloc_req_2};
    fits         = (CNTW'(need) <= count_q);
    alloc_gnt_1  = !rst && fits && alloc_req_1;
    alloc_gnt_2  = !rst && fits && alloc_req_2;
    alloc_stall  = !rst && !fits;
    head_p1      = ptr_inc(head_q);
    alloc_preg_1 = entry_q[head_q];
    alloc_preg_2 = alloc_req_1 ? entry_q[head_p1] : entry_q[head_q];
    n_gnt        = {1'b0, alloc_gnt_1} + {1'b0, alloc_gnt_2};
  end

  // Release screening: double/zero releases first, then room after this cycle's grants.
  always_comb begin
    base = {1'b0, count_q} - (CNTW + 1)'(n_gnt);
    dbl1 = rt_flag_1 && ((fp_i_1 == '0) || free_vec_q[fp_i_1]);
    acc1 = rt_flag_1 && !dbl1 && (base < DEPTH_W);
    ovf1 = rt_flag_1 && !dbl1 && !acc1;
    // Slot 2 repeating an accepted slot-1 index is a double release.
    dbl2 = rt_flag_2 && ((fp_i_2 == '0) || free_vec_q[fp_i_2] || (acc1 && (fp_i_2 == fp_i_1)));
    acc2 = rt_flag_2 && !dbl2 && ((base + (CNTW + 1)'(acc1)) < DEPTH_W);
    ovf2 = rt_flag_2 && !dbl2 && !acc2;
  end

  // Next-state: pop at head, push at tail, maintain free bits, count and sticky errors.
  always_comb begin
    entry_d    = entry_q;
    free_vec_d = free_vec_q;
    if (alloc_gnt_1) free_vec_d[alloc_preg_1] = 1'b0;
    if (alloc_gnt_2) free_vec_d[alloc_preg_2] = 1'b0;

    tail_p1 = tail_q;
    if (acc1) begin
      entry_d[tail_q]    = fp_i_1;
      free_vec_d[fp_i_1] = 1'b1;
      tail_p1            = ptr_inc(tail_q);
    end
    tail_d = tail_p1;
    if (acc2) begin
      entry_d[tail_p1]   = fp_i_2;
      free_vec_d[fp_i_2] = 1'b1;
      tail_d             = ptr_inc(tail_p1);
    end

    case (n_gnt)
      2'd1:    head_d = head_p1;
      2'd2:    head_d = ptr_inc(head_p1);
      default: head_d = head_q;
    endcase

    cnt_sum = base + (CNTW + 1)'(acc1) + (CNTW + 1)'(acc2);
    count_d = (cnt_sum > DEPTH_W) ? CNTW'(DEPTH) : cnt_sum[CNTW-1:0];
    ovf_d   = ovf_q | ovf1 | ovf2;
    dbl_d   = dbl_q | dbl1 | dbl2;
  end

  // State registers; reset refills the list with the unmapped registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      head_q     <= '0;
      tail_q     <= '0;
      count_q    <= CNTW'(DEPTH);
      free_vec_q <= FREE_INIT;
      ovf_q      <= 1'b0;
      dbl_q      <= 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
        entry_q[i] <= IDXW'(NUM_ARCH + i);
      end
    end else begin
      head_q     <= head_d;
      tail_q     <= tail_d;
      count_q    <= count_d;
      free_vec_q <= free_vec_d;
      ovf_q      <= ovf_d;
      dbl_q      <= dbl_d;
      for (int i = 0; i < DEPTH; i++) begin
        entry_q[i] <= entry_d[i];
      end
    end
  end

  assign free_count = count_q;
  assign empty      = (count_q == '0);
  assign ovf_err    = ovf_q;
  assign dbl_err    = dbl_q;

endmodule

// File: tb/tb_phys_free_list.sv
// Directed bench for phys_free_list with hand-computed expectations.
// Inputs change 1 time unit after the rising edge; outputs are checked before the next edge.
// Single checking task counts every comparison and reports mismatches.
module tb_phys_free_list;

  logic       clk = 1'b0;
  logic       rst;
  logic       alloc_req_1, alloc_req_2;
  logic       alloc_gnt_1, alloc_gnt_2;
  logic [5:0] alloc_preg_1, alloc_preg_2;
  logic       alloc_stall;
  logic       rt_flag_1, rt_flag_2;
  logic [5:0] fp_i_1, fp_i_2;
  logic [5:0] free_count;
  logic       empty, ovf_err, dbl_err;

  int n_chk = 0;
  int n_err = 0;

  phys_free_list dut (
    .clk          (clk),
    .rst          (rst),
    .alloc_req_1  (alloc_req_1),
    .alloc_req_2  (alloc_req_2),
    .alloc_gnt_1  (alloc_gnt_1),
    .alloc_gnt_2  (alloc_gnt_2),
    .alloc_preg_1 (alloc_preg_1),
    .alloc_preg_2 (alloc_preg_2),
    .alloc_stall  (alloc_stall),
    .rt_flag_1    (rt_flag_1),
    .fp_i_1       (fp_i_1),
    .rt_flag_2    (rt_flag_2),
    .fp_i_2       (fp_i_2),
    .free_count   (free_count),
    .empty        (empty),
    .ovf_err      (ovf_err),
    .dbl_err      (dbl_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    alloc_req_1 = 1'b0; alloc_req_2 = 1'b0;
    rt_flag_1   = 1'b0; rt_flag_2   = 1'b0;
    fp_i_1      = '0;   fp_i_2      = '0;
  endtask

  task automatic release2(input logic f1, input int v1, input logic f2, input int v2);
    rt_flag_1 = f1; fp_i_1 = 6'(v1);
    rt_flag_2 = f2; fp_i_2 = 6'(v2);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    rst = 1'b1;
    idle();
    tick(); tick();

    // Requests during reset are suppressed
    alloc_req_1 = 1'b1; alloc_req_2 = 1'b1; #1;
    chk("rst_gnt1", alloc_gnt_1, 0);
    chk("rst_gnt2", alloc_gnt_2, 0);
    chk("rst_stall", alloc_stall, 0);
    tick();
    rst = 1'b0; idle(); #1;
    chk("rst_count", free_count, 32);
    chk("rst_empty", empty, 0);
    chk("rst_ovf", ovf_err, 0);
    chk("rst_dbl", dbl_err, 0);

    // First pair
    alloc_req_1 = 1'b1; alloc_req_2 = 1'b1; #1;
    chk("pair0_gnt1", alloc_gnt_1, 1);
    chk("pair0_gnt2", alloc_gnt_2, 1);
    chk("pair0_preg1", alloc_preg_1, 32);
    chk("pair0_preg2", alloc_preg_2, 33);
    chk("pair0_stall", alloc_stall, 0);
    tick();
    idle(); #1;
    chk("pair0_count", free_count, 30);

    // 14 more pairs leave 2 free
    for (int k = 1; k <= 14; k++) begin
      alloc_req_1 = 1'b1; alloc_req_2 = 1'b1; #1;
      chk("pairk_preg1", alloc_preg_1, 32'(32 + 2 * k));
      chk("pairk_preg2", alloc_preg_2, 32'(33 + 2 * k));
      tick();
    end
    idle(); #1;
    chk("two_left_count", free_count, 2);

    alloc_req_1 = 1'b1; #1;
    chk("single_gnt1", alloc_gnt_1, 1);
    chk("single_preg1", alloc_preg_1, 62);
    tick();
    idle(); #1;
    chk("one_left_count", free_count, 1);

    // Two requests with one free: nothing granted
    alloc_req_1 = 1'b1; alloc_req_2 = 1'b1; #1;
    chk("aon_stall", alloc_stall, 1);
    chk("aon_gnt1", alloc_gnt_1, 0);
    chk("aon_gnt2", alloc_gnt_2, 0);
    tick();
    idle(); #1;
    chk("aon_count", free_count, 1);

    // Slot 2 alone takes the head
    alloc_req_2 = 1'b1; #1;
    chk("s2_gnt2", alloc_gnt_2, 1);
    chk("s2_gnt1", alloc_gnt_1, 0);
    chk("s2_preg2", alloc_preg_2, 63);
    chk("s2_stall", alloc_stall, 0);
    tick();
    idle(); #1;
    chk("drain_count", free_count, 0);
    chk("drain_empty", empty, 1);

    alloc_req_1 = 1'b1; #1;
    chk("empty_stall", alloc_stall, 1);
    chk("empty_gnt1", alloc_gnt_1, 0);
    tick();
    idle(); #1;
    chk("empty_count", free_count, 0);

    // Releases are not allocatable in the same cycle
    release2(1'b1, 5, 1'b1, 40);
    alloc_req_1 = 1'b1; #1;
    chk("nobypass_stall", alloc_stall, 1);
    tick();
    idle(); #1;
    chk("rel2_count", free_count, 2);
    chk("rel2_dbl", dbl_err, 0);

    alloc_req_1 = 1'b1; alloc_req_2 = 1'b1; #1;
    chk("realloc_preg1", alloc_preg_1, 5);
    chk("realloc_preg2", alloc_preg_2, 40);
    tick();
    idle(); #1;
    chk("realloc_count", free_count, 0);

    // Same index in both slots
    release2(1'b1, 7, 1'b1, 7);
    tick();
    idle(); #1;
    chk("dup_count", free_count, 1);
    chk("dup_dbl", dbl_err, 1);

    release2(1'b1, 0, 1'b0, 0);
    tick();
    idle(); #1;
    chk("p0_count", free_count, 1);
    chk("p0_dbl", dbl_err, 1);

    alloc_req_1 = 1'b1; #1;
    chk("dup_preg1", alloc_preg_1, 7);
    tick();
    idle(); #1;
    chk("dup_alloc_count", free_count, 0);

    // Refill with 32..63; tail wraps past the end
    for (int k = 0; k < 16; k++) begin
      release2(1'b1, 32 + 2 * k, 1'b1, 33 + 2 * k);
      tick();
    end
    idle(); #1;
    chk("full_count", free_count, 32);
    chk("full_ovf", ovf_err, 0);

    // Full, release alongside a grant: accepted
    release2(1'b1, 5, 1'b0, 0);
    alloc_req_1 = 1'b1; #1;
    chk("full_gnt1", alloc_gnt_1, 1);
    chk("full_preg1", alloc_preg_1, 32);
    tick();
    idle(); #1;
    chk("swap_count", free_count, 32);
    chk("swap_ovf", ovf_err, 0);

    // Full, release without a grant: dropped
    release2(1'b1, 7, 1'b0, 0);
    tick();
    idle(); #1;
    chk("ovf_count", free_count, 32);
    chk("ovf_set", ovf_err, 1);

    // Reset clears sticky errors and restores the list
    rst = 1'b1;
    tick();
    rst = 1'b0; #1;
    chk("rst2_count", free_count, 32);
    chk("rst2_ovf", ovf_err, 0);
    chk("rst2_dbl", dbl_err, 0);
    alloc_req_1 = 1'b1; #1;
    chk("rst2_preg1", alloc_preg_1, 32);
    tick();
    idle();

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
